// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment readback path: active-low segment
// patterns (bits 6..0 = g..a), the error/blank digit code and the frame FSM
// state type.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIGIT_ERR = 4'hF;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the seven-segment encoder: maps an active-low
// 7-bit pattern to a BCD digit, flagging blank (all off) and unknown patterns.
// Blank and unknown patterns both report DIGIT_ERR as the digit value.
module seg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       blank,
  output logic       err
);

  // Table lookup of the ten digit patterns plus blank.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    digit = DIGIT_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Seven-segment display reader. Samples a multiplexed active-low segment bus,
// requires STABLE_CYCLES identical samples per digit before accepting it, and
// presents one complete frame of digits per valid/ready handshake.
// Optional build macro SEVENSEG_READER_CHANGE_ONLY_EN: frames identical to the
// last handshaken frame are dropped instead of presented.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]              seg7;
  logic                    dp_unused;
  logic [3:0]              dec_digit;
  logic                    dec_blank;
  logic                    dec_err;
  logic                    sel_onehot;
  logic                    sel_multi;

  logic [6:0]              last_q [NUM_DIGITS];
  logic [6:0]              last_n [NUM_DIGITS];
  logic [CNT_W-1:0]        cnt_q  [NUM_DIGITS];
  logic [CNT_W-1:0]        cnt_n  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   cap_now;
  logic [NUM_DIGITS-1:0]   captured_q;
  logic [4*NUM_DIGITS-1:0] stage_dig_q,   stage_dig_n;
  logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_n;
  logic [NUM_DIGITS-1:0]   stage_err_q,   stage_err_n;
  state_t                  state_q;
  logic                    frame_done;
  logic                    frame_same;

  // The decimal point does not participate in decoding.
  assign seg7      = seg_in[6:0];
  assign dp_unused = seg_in[7];

  seg_pattern_decode u_decode (
    .pattern (seg7),
    .digit   (dec_digit),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  // Only a clean one-hot strobe updates a filter; multi-hot is a bus fault.
  assign sel_onehot = $onehot(dig_sel);
  assign sel_multi  = !$onehot0(dig_sel);

  // Per-digit stability filter: run-length count of identical samples and
  // capture into staging when the run reaches STABLE_CYCLES.
  always_comb begin
    last_n        = last_q;
    cnt_n         = cnt_q;
    cap_now       = '0;
    stage_dig_n   = stage_dig_q;
    stage_blank_n = stage_blank_q;
    stage_err_n   = stage_err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_onehot && dig_sel[i]) begin
        if (seg7 == last_q[i]) begin
          cnt_n[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_ONE;
        end else begin
          last_n[i] = seg7;
          cnt_n[i]  = CNT_ONE;
        end
        if (cnt_n[i] == CNT_MAX) begin
          cap_now[i]           = 1'b1;
          stage_dig_n[4*i +: 4] = dec_digit;
          stage_blank_n[i]     = dec_blank;
          stage_err_n[i]       = dec_err;
        end
      end
    end
  end

  // Filter and staging registers.
  // NOTE: the small per-digit history is reset so a fresh run always needs a
  // full STABLE_CYCLES of samples; this is flop state, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        last_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stage_dig_q   <= '0;
      stage_blank_q <= '0;
      stage_err_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only.
      last_q        <= last_n;
      cnt_q         <= cnt_n;
      stage_dig_q   <= stage_dig_n;
      stage_blank_q <= stage_blank_n;
      stage_err_q   <= stage_err_n;
    end
  end

  // A frame is complete once every digit has captured, counting this cycle.
  assign frame_done = &(captured_q | cap_now);

`ifdef SEVENSEG_READER_CHANGE_ONLY_EN
  logic [6*NUM_DIGITS-1:0] last_frame_q;
  logic                    last_frame_vld_q;

  assign frame_same = last_frame_vld_q &&
                      ({stage_dig_n, stage_blank_n, stage_err_n} == last_frame_q);

  // Remember the most recently handshaken frame for duplicate suppression.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_frame_q     <= '0;
      last_frame_vld_q <= 1'b0;
    end else if (state_q == PRESENT && out_ready) begin
      last_frame_q     <= {out_digits, out_blank, out_err};
      last_frame_vld_q <= 1'b1;
    end
  end
`else
  assign frame_same = 1'b0;
`endif

  // Frame FSM: collect captures, then hold the frame until it is accepted.
  // An accepting handshake clears captured even if a digit captured that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      captured_q <= '0;
      out_digits <= '0;
      out_blank  <= '0;
      out_err    <= '0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= sel_multi;
      case (state_q)
        COLLECT: begin
          if (frame_done) begin
            captured_q <= '0;
            if (!frame_same) begin
              out_digits <= stage_dig_n;
              out_blank  <= stage_blank_n;
              out_err    <= stage_err_n;
              state_q    <= PRESENT;
            end
          end else begin
            captured_q <= captured_q | cap_now;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            captured_q <= '0;
            state_q    <= COLLECT;
          end else begin
            captured_q <= captured_q | cap_now;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign out_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_sevenseg_reader.sv
// Self-checking bench for sevenseg_reader: table-driven frame scans, directed
// corner sequences, and randomized traffic against a behavioural model.
module tb_sevenseg_reader;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam logic [6:0] REF_PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [4*ND-1:0] out_digits;
  logic [ND-1:0] out_blank;
  logic [ND-1:0] out_err;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;

  always #5 clk = ~clk;

  sevenseg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .out_digits (out_digits),
    .out_blank  (out_blank),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_err    (sel_err)
  );

  int vectors    = 0;
  int miscompares = 0;
  int dut_hs     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A digit is accepted when its last SC selected samples are all identical.
  logic [6:0]    hist [ND][SC];
  int            nsamp [ND];
  logic [3:0]    m_sd [ND];
  logic [ND-1:0] m_sb, m_se, m_capt;
  logic          m_valid, m_selerr, m_last_ok;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0] m_blank, m_err;
  logic [6*ND-1:0] m_last;
  int            m_hs = 0;

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] d,
                                     output logic b, output logic e);
    d = 4'hF;
    b = (p == 7'h7F);
    e = !b;
    for (int k = 0; k < 10; k++)
      if (p == REF_PAT[k]) begin
        d = k[3:0];
        e = 1'b0;
      end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      nsamp[d] = 0;
      m_sd[d]  = 4'h0;
      for (int k = 0; k < SC; k++) hist[d][k] = 7'h00;
    end
    m_sb = '0; m_se = '0; m_capt = '0;
    m_valid = 1'b0; m_selerr = 1'b0; m_last_ok = 1'b0; m_last = '0;
    m_digits = '0; m_blank = '0; m_err = '0;
  endtask

  task automatic model_step(input logic [ND-1:0] s, input logic [6:0] p, input logic r);
    logic [ND-1:0]   cap;
    logic [4*ND-1:0] sd_flat;
    logic [6*ND-1:0] frame;
    logic [3:0]      dd;
    logic            bb, ee, same;
    cap = '0;
    if ($countones(s) == 1) begin
      for (int d = 0; d < ND; d++) if (s[d]) begin
        for (int k = SC - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = p;
        if (nsamp[d] < SC) nsamp[d]++;
        same = 1'b1;
        for (int k = 0; k < SC; k++) if (hist[d][k] != p) same = 1'b0;
        if (nsamp[d] >= SC && same) begin
          cap[d] = 1'b1;
          ref_decode(p, dd, bb, ee);
          m_sd[d] = dd; m_sb[d] = bb; m_se[d] = ee;
        end
      end
    end
    m_selerr = ($countones(s) > 1);
    for (int d = 0; d < ND; d++) sd_flat[4*d +: 4] = m_sd[d];
    frame = {sd_flat, m_sb, m_se};
    if (!m_valid) begin
      if ((m_capt | cap) == '1) begin
        m_capt = '0;
`ifdef SEVENSEG_READER_CHANGE_ONLY_EN
        if (!(m_last_ok && frame == m_last)) begin
`else
        begin
`endif
          m_valid = 1'b1;
          m_digits = sd_flat; m_blank = m_sb; m_err = m_se;
        end
      end else begin
        m_capt = m_capt | cap;
      end
    end else if (r) begin
      m_valid = 1'b0;
      m_capt = '0;
      m_last = {m_digits, m_blank, m_err};
      m_last_ok = 1'b1;
      m_hs++;
    end else begin
      m_capt = m_capt | cap;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 ns after it.
  task automatic cycle(input logic [ND-1:0] s, input logic [7:0] g, input logic r);
    dig_sel = s; seg_in = g; out_ready = r;
    #1;
    if (out_valid && r) dut_hs++;
    @(posedge clk);
    model_step(s, g[6:0], r);
    #1;
    check("out_valid",  32'(out_valid),  32'(m_valid));
    check("out_digits", 32'(out_digits), 32'(m_digits));
    check("out_blank",  32'(out_blank),  32'(m_blank));
    check("out_err",    32'(out_err),    32'(m_err));
    check("sel_err",    32'(sel_err),    32'(m_selerr));
    @(negedge clk);
  endtask

  // Strobe each digit 'per' consecutive cycles, digit 0 first.
  task automatic scan(input logic [31:0] pats, input int per, input logic r);
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < per; k++)
        cycle(ND'(1 << d), pats[8*d +: 8], r);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    dig_sel = '0; seg_in = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0]     pats;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
  } vec_t;

  vec_t tbl [4];
  logic [6:0] disp [ND];
  logic [6:0] pool [12];
  int hs_model_start, hs_dut_start;

  initial begin
    tbl[0] = '{32'h19_30_24_79, 16'h4321, 4'b0000, 4'b0000};
    tbl[1] = '{32'hD5_30_FF_79, 16'hF3F1, 4'b0010, 4'b1000};
    tbl[2] = '{32'h78_02_92_C0, 16'h7650, 4'b0000, 4'b0000};
    tbl[3] = '{32'h7F_40_90_80, 16'hF098, 4'b1000, 4'b0000};
    for (int k = 0; k < 10; k++) pool[k] = REF_PAT[k];
    pool[10] = 7'h7F;
    pool[11] = 7'h55;

    // Reset state
    rst = 1'b1; dig_sel = '0; seg_in = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid",  32'(out_valid),  32'd0);
    check("rst_digits", 32'(out_digits), 32'd0);
    check("rst_blank",  32'(out_blank),  32'd0);
    check("rst_err",    32'(out_err),    32'd0);
    check("rst_sel_err", 32'(sel_err),   32'd0);
    rst = 1'b0;

    // Table-driven frames: scan, check the presented frame, then accept it
    for (int t = 0; t < 4; t++) begin
      scan(tbl[t].pats, SC, 1'b0);
      check("tbl_valid",  32'(out_valid),  32'd1);
      check("tbl_digits", 32'(out_digits), 32'(tbl[t].digits));
      check("tbl_blank",  32'(out_blank),  32'(tbl[t].blank));
      check("tbl_err",    32'(out_err),    32'(tbl[t].err));
      cycle('0, 8'h00, 1'b1);
      check("tbl_accept", 32'(out_valid), 32'd0);
    end

    // Digit 2 flickers between 2 and 3: never stable, no frame
    for (int rnd = 0; rnd < 3; rnd++)
      for (int d = 0; d < ND; d++)
        for (int k = 0; k < SC; k++)
          cycle(ND'(1 << d),
                (d == 2) ? ((k % 2) ? 8'h30 : 8'h24) : ((d == 0) ? 8'h12 : (d == 1) ? 8'h02 : 8'h78),
                1'b0);
    check("flicker_no_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < SC; k++) cycle(4'b0100, 8'h30, 1'b0);
    check("flicker_valid",  32'(out_valid),  32'd1);
    check("flicker_digits", 32'(out_digits), 32'h7365);
    cycle('0, 8'h00, 1'b1);

    // Back-pressure: frame held for 50 cycles while the display changes
    scan(tbl[0].pats, SC, 1'b0);
    for (int c = 0; c < 50; c++) begin
      int d;
      d = (c / SC) % ND;
      cycle(ND'(1 << d), tbl[2].pats[8*d +: 8], 1'b0);
    end
    check("hold_valid",  32'(out_valid),  32'd1);
    check("hold_digits", 32'(out_digits), 32'h4321);
    cycle('0, 8'h00, 1'b1);
    check("hold_accept", 32'(out_valid), 32'd0);
    for (int d = 0; d < ND; d++) cycle(ND'(1 << d), tbl[2].pats[8*d +: 8], 1'b0);
    check("next_valid",  32'(out_valid),  32'd1);
    check("next_digits", 32'(out_digits), 32'h7650);
    cycle('0, 8'h00, 1'b1);

    // Multi-hot strobe flags sel_err for one cycle; zero-hot is silent
    cycle(4'b0110, 8'h79, 1'b0);
    check("sel_err_pulse", 32'(sel_err), 32'd1);
    cycle(4'b0000, 8'h79, 1'b0);
    check("sel_err_clear", 32'(sel_err), 32'd0);

    // Randomized traffic against the model
    for (int d = 0; d < ND; d++) disp[d] = pool[$urandom_range(0, 11)];
    for (int c = 0; c < 600; c++) begin
      logic [ND-1:0] s;
      logic [7:0]    g;
      int            kind, idx;
      if ($urandom_range(0, 19) == 0) disp[$urandom_range(0, ND - 1)] = pool[$urandom_range(0, 11)];
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, ND - 1);
      if (kind < 8) begin
        s = ND'(1 << idx);
        g = {1'($urandom_range(0, 1)), disp[idx]};
      end else if (kind == 8) begin
        s = '0;
        g = 8'($urandom);
      end else begin
        s = ND'($urandom_range(0, 15));
        g = 8'($urandom);
      end
      cycle(s, g, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while a frame is presented
    apply_reset();
    scan(tbl[0].pats, SC, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid",  32'(out_valid),  32'd0);
    check("async_rst_digits", 32'(out_digits), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    scan(tbl[0].pats, SC - 1, 1'b0);
    check("rst_refill_short", 32'(out_valid), 32'd0);
    scan(tbl[0].pats, 1, 1'b0);
    check("rst_refill_valid",  32'(out_valid),  32'd1);
    check("rst_refill_digits", 32'(out_digits), 32'h4321);

    // Static display with ready held high: count handshakes
    hs_model_start = m_hs;
    hs_dut_start   = dut_hs;
    for (int rnd = 0; rnd < 3; rnd++) scan(tbl[0].pats, SC, 1'b1);
    check("static_hs_count", 32'(dut_hs - hs_dut_start), 32'(m_hs - hs_model_start));
`ifdef SEVENSEG_READER_CHANGE_ONLY_EN
    check("change_only_one_hs", 32'(dut_hs - hs_dut_start), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
